// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: execute-stage front end for the iterative 64x64->128
// unsigned shift-add multiplier core. Accepts RV64M multiply ops, feeds the
// core operand magnitudes, then sign-corrects and selects the rd value.
module mul_issue_ctrl #(
  parameter int XLEN = 64,  // the core is fixed at 64x64->128; only 64 is supported
  parameter int OP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     op,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     result,
  output logic                busy,
  output logic                core_en,
  output logic [XLEN-1:0]     core_multiplier,
  output logic [XLEN-1:0]     core_multiplicand,
  input  logic [2*XLEN-1:0]   core_product,
  input  logic                core_compl
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MULW   = OP_W'(4);

  localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_P = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [1:0]        state_reg, state_next;
  logic [OP_W-1:0]   op_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   mult_reg, mcand_reg, result_reg;

  logic [OP_W-1:0]   op_eff;
  logic              s1_sgn, s2_sgn, neg_in, zero_in, accept;
  logic [XLEN-1:0]   mag1, mag2, res_sel;
  logic [2*XLEN-1:0] prod_fix;

  assign accept = (state_reg == ST_IDLE) && in_valid && !flush;

  // Operand decode at accept: reserved ops fold onto MULHU, signed sources
  // become magnitudes (abs(-2^63) wraps to 2^63, which is the right unsigned value).
  always_comb begin
    op_eff = (op > OP_MULW) ? OP_MULHU : op;
    s1_sgn = (op_eff == OP_MUL) || (op_eff == OP_MULH) || (op_eff == OP_MULHSU);
    s2_sgn = (op_eff == OP_MUL) || (op_eff == OP_MULH);
    if (op_eff == OP_MULW) begin
      mag1   = {{(XLEN-32){1'b0}}, src1[31:0]};
      mag2   = {{(XLEN-32){1'b0}}, src2[31:0]};
      neg_in = 1'b0;
    end else begin
      mag1   = (s1_sgn && src1[XLEN-1]) ? (~src1 + ONE_X) : src1;
      mag2   = (s2_sgn && src2[XLEN-1]) ? (~src2 + ONE_X) : src2;
      neg_in = (s1_sgn & src1[XLEN-1]) ^ (s2_sgn & src2[XLEN-1]);
    end
    zero_in = (mag1 == '0) || (mag2 == '0);
  end

  // Sign correction of the unsigned core product and rd selection.
  always_comb begin
    prod_fix = neg_reg ? (~core_product + ONE_P) : core_product;
    case (op_reg)
      OP_MUL:  res_sel = prod_fix[XLEN-1:0];
      OP_MULW: res_sel = {{(XLEN-32){prod_fix[31]}}, prod_fix[31:0]};
      default: res_sel = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state logic; flush overrides every transition, including DONE handoff.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = zero_in ? ST_DONE : ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (core_compl) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // State, captured op/operands and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      mult_reg   <= '0;
      mcand_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= op_eff;
        neg_reg   <= neg_in;
        mult_reg  <= mag1;
        mcand_reg <= mag2;
        if (zero_in) result_reg <= '0;
      end
      if ((state_reg == ST_WAIT) && core_compl && !flush) result_reg <= res_sel;
    end
  end

  assign in_ready          = (state_reg == ST_IDLE);
  assign busy              = (state_reg != ST_IDLE);
  assign out_valid         = (state_reg == ST_DONE);
  assign core_en           = (state_reg == ST_START);
  assign core_multiplier   = mult_reg;
  assign core_multiplicand = mcand_reg;
  assign result            = result_reg;

  // Reserved op encodings are tolerated in hardware but flagged in simulation.
  a_reserved_op: assert property (@(posedge clk) disable iff (reset) accept |-> (op <= OP_MULW));

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed + randomized bench for mul_issue_ctrl with a
// behavioural 64-iteration multiplier core and an arithmetic reference model.
module tb_mul_issue_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [63:0]  src1 = '0;
  logic [63:0]  src2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  result;
  logic         busy;
  logic         core_en;
  logic [63:0]  core_multiplier;
  logic [63:0]  core_multiplicand;
  logic [127:0] core_product = '0;
  logic         core_compl = 1'b0;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int core_iter = 0;
  logic [63:0] lat_a = '0;
  logic [63:0] lat_b = '0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(64), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
    .core_en(core_en), .core_multiplier(core_multiplier),
    .core_multiplicand(core_multiplicand),
    .core_product(core_product), .core_compl(core_compl)
  );

  // Multiplier core model: core_en clears and restarts it; the product (and
  // sticky done flag) appear after 64 iterations. Garbage product meanwhile.
  always @(posedge clk) begin
    if (core_en) begin
      core_iter    <= 0;
      core_compl   <= 1'b0;
      lat_a        <= core_multiplier;
      lat_b        <= core_multiplicand;
      core_product <= {$urandom, $urandom, $urandom, $urandom};
    end else if (!core_compl) begin
      core_iter <= core_iter + 1;
      if (core_iter == 63) begin
        core_compl   <= 1'b1;
        core_product <= {64'd0, lat_a} * {64'd0, lat_b};
      end
    end
  end

  // Count cycles in which the core start pulse is high.
  always @(posedge clk) if (core_en) en_cnt <= en_cnt + 1;

  // Reference: RV64M semantics as plain 128-bit arithmetic on extended sources.
  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, za, sb, zb, p;
    logic [63:0]  w;
    sa = {{64{a[63]}}, a}; za = {64'd0, a};
    sb = {{64{b[63]}}, b}; zb = {64'd0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * zb; return p[127:64]; end
      3'd4: begin w = {32'd0, a[31:0]} * {32'd0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
      default: begin p = za * zb; return p[127:64]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic zero;
    zero = (o == 3'd4) ? ((a[31:0] == 32'd0) || (b[31:0] == 32'd0)) : ((a == 64'd0) || (b == 64'd0));
    return zero ? 0 : 66;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction, entered and left #1 after a rising edge. lat counts edges
  // after the accept edge until out_valid is seen (0 = visible right after accept).
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input int hold);
    int lat;
    int en0;
    logic [63:0] exp;
    exp = ref_mul(o, a, b);
    check("in_ready_before_accept", in_ready, 1);
    en0 = en_cnt;
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(ref_lat(o, a, b)));
    check("result", result, exp);
    check("core_en_pulses", 64'(en_cnt - en0), (ref_lat(o, a, b) == 0) ? 64'd0 : 64'd1);
    $display("[TB] op=%0d src1=%h src2=%h result=%h lat=%0d", o, a, b, result, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, exp);
      check("hold_busy", busy, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_core_en", core_en, 0);
    check("rst_multiplier", core_multiplier, 0);
    check("rst_multiplicand", core_multiplicand, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed ops
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    run_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0);
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 0);
    run_op(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd4, 64'h0000_0001_4000_0000, 64'd2, 0);

    // Zero bypass
    run_op(3'd0, 64'h1234, 64'd0, 0);
    run_op(3'd4, 64'd3, 64'h0000_0005_0000_0000, 0);

    // Backpressure, then an accept on the cycle right after the drain
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 10);
    run_op(3'd0, 64'd11, 64'd13, 0);

    // Flush on the 30th WAIT cycle
    op = 3'd3; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("pre_flush_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    run_op(3'd0, 64'd5, 64'd6, 0);

    // Reset mid-WAIT
    op = 3'd1; src1 = 64'hFFFF_FFFF_FFFF_FFF0; src2 = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_state();
    run_op(3'd0, 64'd5, 64'd6, 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 20; n++) begin
      logic [2:0]  ro;
      logic [63:0] ra, rb;
      ro = 3'($urandom_range(0, 4));
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Execute-stage front end for the iterative 64-bit unsigned shift-add multiplier core. It accepts RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) over a valid/ready handshake and converts signed operands to magnitudes. It drives the core's start/operand ports, waits for the core's completion flag, then applies sign correction and result selection. The result is held on a valid/ready output to writeback until consumed.

Parameters:
XLEN, 64, operand/result width; the core is fixed at 64x64->128, and no other value is supported.
OP_W, 3, width of op encoding.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
flush  input  1  synchronous kill of any in-flight op
in_valid  input  1  op request
in_ready  output  1  high only in IDLE
op  input  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW; 5-7 reserved
src1  input  64  rs1 value
src2  input  64  rs2 value
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  64  final rd value, registered
busy  output  1  state != IDLE
core_en  output  1  one-cycle start/clear pulse to multiplier core
core_multiplier  output  64  magnitude of operand A, registered
core_multiplicand  output  64  magnitude of operand B, registered
core_product  input  128  unsigned product from core
core_compl  input  1  core done flag; sticky until next core_en

Behaviour:
- Reset values: state=IDLE, out_valid=0, result=0, core_en=0, core operands=0, negate flag=0, op register=0.
- States: IDLE, START, WAIT, DONE.
- IDLE: in_ready=1. Accept = in_valid && !flush. On accept, register op and operand magnitudes:
  - MUL/MULH: both signed; take abs of each; neg = src1[63]^src2[63].
  - MULHSU: src1 signed, src2 unsigned; neg = src1[63].
  - MULHU: both unsigned; neg = 0.
  - MULW: zero-extended src[31:0] of each; neg = 0.
  - abs(-2^63) = 2^63, represented as an unsigned 64-bit value.
- Zero bypass: if either operand (low 32 bits for MULW) is 0 at accept, go IDLE->DONE with result=0 and never start the core. out_valid is high in the cycle after the accept edge.
- Otherwise go IDLE->START.
- START (1 cycle): core_en=1, operands stable, then go to WAIT. core_en is 0 in every other state.
- WAIT: core_compl is sampled only here. The core clears it on the core_en edge, so it is always valid in WAIT. On core_compl=1:
  - compute P = neg ? (~core_product + 1) : core_product, 128-bit two's complement.
  - Register result: MUL -> P[63:0]; MULH/MULHSU/MULHU -> P[127:64]; MULW -> sext(P[31:0]).
  - Go to DONE.
- Latency: the core needs 64 iterations. out_valid rises exactly 66 cycles after the accept edge. The bench checks this exact count.
- DONE: out_valid=1, result stable. On out_ready go to IDLE. There is no same-cycle re-accept; the next accept is possible the cycle after.
- Backpressure: DONE holds indefinitely with result unchanged and in_ready=0.
- flush=1 in any state: next state is IDLE and out_valid=0 next cycle. Accept is suppressed that cycle. flush beats out_ready in DONE, so the result is dropped and the consumer ignores it. The core may keep iterating; the next START's core_en restarts it cleanly.
- reset mid-operation: same effect as flush, plus all registers return to their reset values.
- Reserved op (5-7): treat as MULHU. Assertion-flagged in simulation.
- core_product is read only in the WAIT cycle where core_compl=1. Stale core_compl outside WAIT is ignored.

Test Plan:
- MULHU src1=0xFFFFFFFFFFFFFFFF, src2=2 -> result=0x0000000000000001; out_valid exactly 66 cycles after the accept edge; core_en high for exactly 1 cycle.
- MUL src1=0xFFFFFFFFFFFFFFFD (-3), src2=7 -> result=0xFFFFFFFFFFFFFFEB. MULH with the same operands -> 0xFFFFFFFFFFFFFFFF. MULH src1=src2=0x8000000000000000 -> 0x4000000000000000.
- MULHSU src1=0xFFFFFFFFFFFFFFFF, src2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF. MULW src1=0x0000000140000000, src2=2 -> 0xFFFFFFFF80000000.
- Zero bypass: MUL src1=0x1234, src2=0 -> out_valid 1 cycle after accept, result=0, core_en never asserted. MULW src2=0x0000000500000000 also bypasses.
- Backpressure: out_ready low for 10 cycles in DONE -> out_valid, result and busy held, in_ready=0. out_ready high -> IDLE next cycle, then a new accept on the following cycle.
- flush on the 30th WAIT cycle -> IDLE next cycle, no out_valid. An immediately following MUL 5x6 -> result=30 after 66 cycles. A reset asserted mid-WAIT gives the same recovery with all outputs at their reset values.
